// File: rtl/delivery_game_v2.sv
// delivery_game_v2: delivery game core. Scrolling obstacle/objective map, lane-based player,
// lives, score and a velocity-controlled scroll rate, sequenced by one control FSM.
//
// Optional feature: define DELIVERY_LIVES_EN to enable the lives counter. Without it, the first
// obstacle hit ends the game and vidas is tied to 0.
//
// Ports:
//   clock              in   system clock, rising edge
//   reset              in   synchronous, active-low
//   jogar              in   start/restart request (level)
//   botoes[1:0]        in   [0]=left, [1]=right, rising-edge detected
//   velocidade         in   scroll velocity, larger is faster
//   velocidade_valid   in   one-cycle strobe latching velocidade
//   estado             out  FSM state code
//   pontuacao          out  score
//   vidas              out  remaining lives
//   pronto             out  high while in GAME_OVER
//   vitoria            out  game ended by reaching the maximum score
//   db_player_position out  player lane
//   db_map_obstacle    out  obstacle bitmap, bit r*LANES+l = row r, lane l
//   db_map_objective   out  objective bitmap, same packing
module delivery_game_v2 #(
  parameter int unsigned LANES     = 4,
  parameter int unsigned ROWS      = 16,
  parameter int unsigned SCORE_W   = 3,
  parameter int unsigned LIVES     = 3,
  parameter int unsigned VEL_W     = 4,
  parameter int unsigned TICK_UNIT = 1000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    jogar,
  input  logic [1:0]              botoes,
  input  logic [VEL_W-1:0]        velocidade,
  input  logic                    velocidade_valid,
  output logic [3:0]              estado,
  output logic [SCORE_W-1:0]      pontuacao,
  output logic [3:0]              vidas,
  output logic                    pronto,
  output logic                    vitoria,
  output logic [3:0]              db_player_position,
  output logic [ROWS*LANES-1:0]   db_map_obstacle,
  output logic [ROWS*LANES-1:0]   db_map_objective
);

  localparam int unsigned LB        = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned MapW      = ROWS * LANES;
  localparam int unsigned PeriodMax = (2 ** VEL_W) * TICK_UNIT;
  localparam int unsigned CntW      = $clog2(PeriodMax + 1);

  localparam logic [3:0]         MidLane  = 4'(LANES / 2);
  localparam logic [3:0]         LastLane = 4'(LANES - 1);
  localparam logic [SCORE_W-1:0] ScoreMax = '1;
  localparam logic [LANES-1:0]   LaneOne  = LANES'(1);

  if (LANES < 2 || LANES > 16 || LIVES < 1 || LIVES > 15 || ROWS < 2) begin : g_bad_params
    $error("delivery_game_v2: parameter out of range");
  end

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StInit     = 4'd1,
    StPlay     = 4'd2,
    StScroll   = 4'd3,
    StCheck    = 4'd4,
    StGameOver = 4'd5
  } state_e;

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0]         pos_q, pos_d;
  logic [MapW-1:0]    obs_q, obs_d;
  logic [MapW-1:0]    obj_q, obj_d;
  logic [CntW-1:0]    tick_q, tick_d;
  logic [VEL_W-1:0]   vel_q, vel_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic               vit_q, vit_d;
  logic [1:0]         btn_q;
`ifdef DELIVERY_LIVES_EN
  logic [3:0]         lives_q, lives_d;
`endif

  logic [1:0]         btn_rise;
  logic [CntW-1:0]    period;
  logic [LB-1:0]      obs_lane, obj_lane;
  logic               obs_ok, obj_ok;
  logic [LANES-1:0]   gen_obs, gen_obj, pos_oh;
  logic               hit, got;
  logic [SCORE_W-1:0] score_inc;

  assign btn_rise  = botoes & ~btn_q;
  assign period    = CntW'(((2 ** VEL_W) - 32'(vel_q)) * TICK_UNIT);

  // New top row decoded from the current LFSR value; lanes past LANES-1 mean "none".
  assign obs_lane  = lfsr_q[LB-1:0];
  assign obj_lane  = lfsr_q[8+LB-1:8];
  assign obs_ok    = 32'(obs_lane) < LANES;
  assign obj_ok    = (32'(obj_lane) < LANES) && (obj_lane != obs_lane);
  assign gen_obs   = obs_ok ? (LaneOne << obs_lane) : '0;
  assign gen_obj   = obj_ok ? (LaneOne << obj_lane) : '0;

  assign pos_oh    = LaneOne << pos_q;
  assign hit       = |(obs_q[LANES-1:0] & pos_oh);
  assign got       = |(obj_q[LANES-1:0] & pos_oh);
  assign score_inc = score_q + 1'b1;

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    pos_d   = pos_q;
    obs_d   = obs_q;
    obj_d   = obj_q;
    tick_d  = tick_q;
    lfsr_d  = lfsr_q;
    vit_d   = vit_q;
`ifdef DELIVERY_LIVES_EN
    lives_d = lives_q;
`endif
    vel_d   = velocidade_valid ? velocidade : vel_q;

    unique case (state_q)
      StIdle: begin
        if (jogar) state_d = StInit;
      end
      StInit: begin
        obs_d   = '0;
        obj_d   = '0;
        score_d = '0;
`ifdef DELIVERY_LIVES_EN
        lives_d = 4'(LIVES);
`endif
        pos_d   = MidLane;
        vit_d   = 1'b0;
        tick_d  = period;
        state_d = StPlay;
      end
      StPlay: begin
        tick_d = tick_q - 1'b1;
        if (btn_rise == 2'b01 && pos_q != 4'd0) begin
          pos_d = pos_q - 1'b1;
        end else if (btn_rise == 2'b10 && pos_q != LastLane) begin
          pos_d = pos_q + 1'b1;
        end
        if (tick_q == CntW'(1)) state_d = StScroll;
      end
      StScroll: begin
        obs_d   = {gen_obs, obs_q[MapW-1:LANES]};
        obj_d   = {gen_obj, obj_q[MapW-1:LANES]};
        // Fibonacci LFSR, taps 16,14,13,11 (right-shifting form).
        lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        state_d = StCheck;
      end
      StCheck: begin
        state_d = StPlay;
        tick_d  = period;
        if (hit) begin
          obs_d[LANES-1:0] = obs_q[LANES-1:0] & ~pos_oh;
`ifdef DELIVERY_LIVES_EN
          lives_d = (lives_q != 4'd0) ? lives_q - 1'b1 : 4'd0;
          if (lives_q <= 4'd1) begin
            state_d = StGameOver;
            vit_d   = 1'b0;
          end
`else
          state_d = StGameOver;
          vit_d   = 1'b0;
`endif
        end else if (got) begin
          obj_d[LANES-1:0] = obj_q[LANES-1:0] & ~pos_oh;
          score_d          = score_inc;
          if (score_inc == ScoreMax) begin
            state_d = StGameOver;
            vit_d   = 1'b1;
          end
        end
      end
      StGameOver: begin
        if (jogar) state_d = StInit;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIdle;
      score_q <= '0;
      pos_q   <= '0;
      obs_q   <= '0;
      obj_q   <= '0;
      tick_q  <= '0;
      vel_q   <= '0;
      lfsr_q  <= 16'hACE1;
      vit_q   <= 1'b0;
      btn_q   <= '0;
`ifdef DELIVERY_LIVES_EN
      lives_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      pos_q   <= pos_d;
      obs_q   <= obs_d;
      obj_q   <= obj_d;
      tick_q  <= tick_d;
      vel_q   <= vel_d;
      lfsr_q  <= lfsr_d;
      vit_q   <= vit_d;
      btn_q   <= botoes;
`ifdef DELIVERY_LIVES_EN
      lives_q <= lives_d;
`endif
    end
  end

  assign estado             = state_q;
  assign pontuacao          = score_q;
`ifdef DELIVERY_LIVES_EN
  assign vidas              = lives_q;
`else
  assign vidas              = 4'd0;
`endif
  assign pronto             = (state_q == StGameOver);
  assign vitoria            = vit_q;
  assign db_player_position = pos_q;
  assign db_map_obstacle    = obs_q;
  assign db_map_objective   = obj_q;

endmodule

// File: tb/tb_delivery_game_v2.sv
// Randomized bench for delivery_game_v2 against a game-rule reference model.
module tb_delivery_game_v2;

  localparam int unsigned LANES     = 4;
  localparam int unsigned ROWS      = 16;
  localparam int unsigned SCORE_W   = 3;
  localparam int unsigned LIVES     = 3;
  localparam int unsigned VEL_W     = 4;
  localparam int unsigned TICK_UNIT = 2;
  localparam int          LB        = $clog2(LANES);
  localparam int          NCycles   = 20000;
`ifdef DELIVERY_LIVES_EN
  localparam bit LivesEn = 1'b1;
`else
  localparam bit LivesEn = 1'b0;
`endif

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  jogar;
  logic [1:0]            botoes;
  logic [VEL_W-1:0]      velocidade;
  logic                  velocidade_valid;
  logic [3:0]            estado;
  logic [SCORE_W-1:0]    pontuacao;
  logic [3:0]            vidas;
  logic                  pronto;
  logic                  vitoria;
  logic [3:0]            db_player_position;
  logic [ROWS*LANES-1:0] db_map_obstacle;
  logic [ROWS*LANES-1:0] db_map_objective;

  delivery_game_v2 #(
    .LANES    (LANES),
    .ROWS     (ROWS),
    .SCORE_W  (SCORE_W),
    .LIVES    (LIVES),
    .VEL_W    (VEL_W),
    .TICK_UNIT(TICK_UNIT)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .jogar             (jogar),
    .botoes            (botoes),
    .velocidade        (velocidade),
    .velocidade_valid  (velocidade_valid),
    .estado            (estado),
    .pontuacao         (pontuacao),
    .vidas             (vidas),
    .pronto            (pronto),
    .vitoria           (vitoria),
    .db_player_position(db_player_position),
    .db_map_obstacle   (db_map_obstacle),
    .db_map_objective  (db_map_objective)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: game state in plain integers and 2-D cell arrays.
  int       m_state, m_score, m_lives, m_pos, m_tick, m_vel, m_lfsr;
  bit       m_vit;
  bit [1:0] m_btn;
  bit       m_obs[ROWS][LANES];
  bit       m_obj[ROWS][LANES];

  function automatic logic [63:0] pack_map(input bit objective);
    logic [63:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int l = 0; l < LANES; l++)
        v[r*LANES+l] = objective ? m_obj[r][l] : m_obs[r][l];
    return v;
  endfunction

  task automatic model_step(input bit rst_n, input bit jg, input bit [1:0] b, input int v,
                            input bit vv);
    bit [1:0] rise;
    int       period, ol, jl, fb;
    if (!rst_n) begin
      m_state = 0; m_score = 0; m_lives = 0; m_pos = 0; m_tick = 0; m_vel = 0;
      m_lfsr = 'hACE1; m_vit = 0; m_btn = 0;
      for (int r = 0; r < ROWS; r++)
        for (int l = 0; l < LANES; l++) begin
          m_obs[r][l] = 0;
          m_obj[r][l] = 0;
        end
      return;
    end
    rise   = b & ~m_btn;
    m_btn  = b;
    // The scroll period uses the velocity held before this cycle's strobe.
    period = ((1 << VEL_W) - m_vel) * TICK_UNIT;
    if (vv) m_vel = v;
    case (m_state)
      0: if (jg) m_state = 1;
      1: begin
        for (int r = 0; r < ROWS; r++)
          for (int l = 0; l < LANES; l++) begin
            m_obs[r][l] = 0;
            m_obj[r][l] = 0;
          end
        m_score = 0;
        m_lives = LivesEn ? LIVES : 0;
        m_pos   = LANES / 2;
        m_vit   = 0;
        m_tick  = period;
        m_state = 2;
      end
      2: begin
        if (rise == 2'b01) m_pos = (m_pos > 0) ? m_pos - 1 : 0;
        else if (rise == 2'b10) m_pos = (m_pos < LANES - 1) ? m_pos + 1 : LANES - 1;
        if (m_tick == 1) m_state = 3;
        m_tick = m_tick - 1;
      end
      3: begin
        for (int r = 0; r < ROWS - 1; r++)
          for (int l = 0; l < LANES; l++) begin
            m_obs[r][l] = m_obs[r+1][l];
            m_obj[r][l] = m_obj[r+1][l];
          end
        for (int l = 0; l < LANES; l++) begin
          m_obs[ROWS-1][l] = 0;
          m_obj[ROWS-1][l] = 0;
        end
        ol = m_lfsr % (1 << LB);
        jl = (m_lfsr >> 8) % (1 << LB);
        if (ol < LANES) m_obs[ROWS-1][ol] = 1;
        if (jl < LANES && jl != ol) m_obj[ROWS-1][jl] = 1;
        fb     = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
        m_lfsr = (m_lfsr >> 1) | (fb << 15);
        m_state = 4;
      end
      4: begin
        m_state = 2;
        m_tick  = period;
        if (m_obs[0][m_pos]) begin
          m_obs[0][m_pos] = 0;
          if (LivesEn) begin
            m_lives = m_lives - 1;
            if (m_lives <= 0) begin
              m_lives = 0;
              m_state = 5;
              m_vit   = 0;
            end
          end else begin
            m_state = 5;
            m_vit   = 0;
          end
        end else if (m_obj[0][m_pos]) begin
          m_obj[0][m_pos] = 0;
          m_score = m_score + 1;
          if (m_score == (1 << SCORE_W) - 1) begin
            m_state = 5;
            m_vit   = 1;
          end
        end
      end
      5: if (jg) m_state = 1;
      default: m_state = 0;
    endcase
  endtask

  // Steer toward an arriving objective, or away from an arriving obstacle.
  function automatic int steer_target();
    for (int r = 1; r >= 0; r--)
      for (int l = 0; l < LANES; l++)
        if (m_obj[r][l] && !m_obs[r][l]) return l;
    if (m_obs[1][m_pos]) return (m_pos == 0) ? 1 : m_pos - 1;
    return -1;
  endfunction

  initial begin
    bit       r_n, jg, vv;
    bit [1:0] b;
    int       v, tgt;
    reset = 1'b0; jogar = 1'b0; botoes = '0; velocidade = '0; velocidade_valid = 1'b0;
    b = '0;
    for (int cyc = 0; cyc < NCycles && n_errors < 30; cyc++) begin
      @(negedge clock);
      r_n = !(cyc < 2 || $urandom_range(0, 1499) == 0 ||
              (m_state == 4 && $urandom_range(0, 39) == 0));
      if (cyc == 2) jg = 1'b1;
      else if (m_state == 0 || m_state == 5) jg = ($urandom_range(0, 7) == 0);
      else jg = ($urandom_range(0, 15) == 0);
      vv = ($urandom_range(0, 63) == 0);
      v  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(10, 15);
      if (b != 2'b00 && $urandom_range(0, 3) != 0) begin
        b = 2'b00;
      end else if ($urandom_range(0, 9) == 0) begin
        b = 2'($urandom_range(0, 3));
      end else begin
        tgt = steer_target();
        if (tgt >= 0 && tgt < m_pos) b = 2'b01;
        else if (tgt > m_pos) b = 2'b10;
        else b = 2'b00;
      end
      reset = r_n; jogar = jg; botoes = b;
      velocidade = VEL_W'(v); velocidade_valid = vv;
      model_step(r_n, jg, b, v, vv);
      @(posedge clock);
      #1;
      check_eq("estado", 64'(estado), 64'(m_state));
      check_eq("pontuacao", 64'(pontuacao), 64'(m_score));
      check_eq("vidas", 64'(vidas), 64'(m_lives));
      check_eq("pronto", 64'(pronto), 64'(m_state == 5));
      check_eq("vitoria", 64'(vitoria), 64'(m_vit));
      check_eq("position", 64'(db_player_position), 64'(m_pos));
      check_eq("map_obstacle", 64'(db_map_obstacle), pack_map(1'b0));
      check_eq("map_objective", 64'(db_map_objective), pack_map(1'b1));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
